// File: rtl/sseg_scan_driver_if.sv
// Display-side signal bundle for the 4-digit scan driver: BCD digits and
// decimal points in, multiplexed anode/segment drive out.
interface sseg_scan_driver_if;
  // No handshake: the producer holds digit_in/dp_in/blank_en as levels and the
  // driver samples them (digits/dp once per frame, blank_en every cycle).
  logic [3:0] digit_in [3:0];
  logic [3:0] dp_in;
  logic       blank_en;
  logic [3:0] an;
  logic [7:0] sseg;

  modport master (output digit_in, dp_in, blank_en, input an, sseg);
  modport slave  (input digit_in, dp_in, blank_en, output an, sseg);
endinterface

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed common-anode 4-digit 7-segment driver with per-frame input
// snapshot, decimal points and leading-zero blanking.
module sseg_scan_driver #(
  parameter int N = 18
) (
  input logic               clk,
  input logic               clr,
  sseg_scan_driver_if.slave disp
);

  localparam logic [N-1:0] ONE = 1;

  logic [N-1:0] q;
  logic [3:0]   snap_digit [3:0];
  logic [3:0]   snap_dp;
  logic [3:0]   an_q;
  logic [7:0]   sseg_q;

  logic [1:0]   sel;
  logic [3:0]   cur;
  logic [3:0]   upper_zero;
  logic         blank;
  logic [6:0]   seg_code;
  logic [3:0]   an_next;
  logic [7:0]   sseg_next;

  assign sel = q[N-1:N-2];
  assign cur = snap_digit[sel];

  // upper_zero[k]: digits k..3 are all zero with no decimal point requested
  always_comb begin
    upper_zero    = '0;
    upper_zero[3] = (snap_digit[3] == 4'd0) && !snap_dp[3];
    upper_zero[2] = upper_zero[3] && (snap_digit[2] == 4'd0) && !snap_dp[2];
    upper_zero[1] = upper_zero[2] && (snap_digit[1] == 4'd0) && !snap_dp[1];
    upper_zero[0] = upper_zero[1] && (snap_digit[0] == 4'd0) && !snap_dp[0];
  end

  assign blank = disp.blank_en && (sel != 2'd0) && upper_zero[sel];

  always_comb begin
    seg_code = 7'h3F;
    case (cur)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h3F;
    endcase
  end

  assign an_next   = ~(4'b0001 << sel);
  assign sseg_next = {~snap_dp[sel], blank ? 7'h7F : seg_code};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q       <= '0;
      snap_dp <= '0;
      an_q    <= 4'hF;
      sseg_q  <= 8'hFF;
      for (int i = 0; i < 4; i++) snap_digit[i] <= '0;
    end else begin
      q      <= q + ONE;
      an_q   <= an_next;
      sseg_q <= sseg_next;
      // Capture on the last count so the new frame starts from consistent data
      if (q == '1) begin
        snap_dp <= disp.dp_in;
        for (int i = 0; i < 4; i++) snap_digit[i] <= disp.digit_in[i];
      end
    end
  end

  assign disp.an   = an_q;
  assign disp.sseg = sseg_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver with N=4 (16-clock frame): directed frames with
// hand-computed per-digit segment codes checked by a decoupled scoreboard.
module tb_sseg_scan_driver;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_on = 1'b0;
  logic [11:0] exp_q[$];

  sseg_scan_driver_if bus ();

  sseg_scan_driver #(.N(4)) dut (
    .clk  (clk),
    .clr  (clr),
    .disp (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Monitor: one expected {an,sseg} per clock while the scan is being checked
  always @(posedge clk) begin
    logic [11:0] e;
    #1;
    cyc++;
    if (mon_on) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scan_underflow cyc=%0d got an=%b sseg=%h, no expected entry", cyc, bus.an, bus.sseg);
      end else begin
        e = exp_q.pop_front();
        if ({bus.an, bus.sseg} !== e) begin
          failures++;
          $display("FAIL scan cyc=%0d got an=%b sseg=%h expected an=%b sseg=%h",
                   cyc, bus.an, bus.sseg, e[11:8], e[7:0]);
        end
      end
    end
  end

  task automatic check_reset(input string name);
    checks++;
    if (bus.an !== 4'hF || bus.sseg !== 8'hFF) begin
      failures++;
      $display("FAIL %s got an=%b sseg=%h expected an=1111 sseg=ff", name, bus.an, bus.sseg);
    end
  endtask

  task automatic set_inputs(input logic [15:0] nd, input logic [3:0] ndp);
    bus.digit_in[0] = nd[3:0];
    bus.digit_in[1] = nd[7:4];
    bus.digit_in[2] = nd[11:8];
    bus.digit_in[3] = nd[15:12];
    bus.dp_in       = ndp;
  endtask

  // Push one frame of expectations (e0..e3 = sseg for digit 0..3) and run it;
  // at frame cycle chg_at (the cycle q==chg_at) new inputs are applied.
  task automatic run_frame(input logic [7:0] e0, e1, e2, e3, input int chg_at,
                           input logic [15:0] nd, input logic [3:0] ndp);
    logic [7:0] e [4];
    logic [3:0] a;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < 16; i++) begin
      a = ~(4'b0001 << (i / 4));
      exp_q.push_back({a, e[i / 4]});
    end
    mon_on = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == chg_at) set_inputs(nd, ndp);
      @(negedge clk);
    end
  endtask

  initial begin
    set_inputs(16'h0000, 4'h0);
    bus.blank_en = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset_initial");

    clr = 1'b0;
    // Frame 0: snapshot zeros, no blanking
    run_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 0, 16'h3210, 4'b0010);
    // Frame 1: scan order 0,1.,2,3
    run_frame(8'hC0, 8'h79, 8'hA4, 8'hB0, 0, 16'h0005, 4'b0010);
    // Frame 2: leading-zero blanking with dp on digit 1
    bus.blank_en = 1'b1;
    run_frame(8'h92, 8'h40, 8'hFF, 8'hFF, 0, 16'h1111, 4'b0000);
    // Frame 3: inputs change at q=5, frame keeps showing 1s
    bus.blank_en = 1'b0;
    run_frame(8'hF9, 8'hF9, 8'hF9, 8'hF9, 5, 16'h2222, 4'b0000);
    // Frame 4: new snapshot shows 2s
    run_frame(8'hA4, 8'hA4, 8'hA4, 8'hA4, 0, 16'h4C98, 4'b1000);
    // Frame 5: invalid BCD on digit 2, dp on digit 3
    run_frame(8'h80, 8'h90, 8'hBF, 8'h19, 0, 16'h0070, 4'b0000);
    // Frame 6: blanking stops at the highest nonzero digit
    bus.blank_en = 1'b1;
    run_frame(8'hC0, 8'hF8, 8'hFF, 8'hFF, 0, 16'h0000, 4'b0000);
    // Frame 7: all zeros, digit 0 never blanked
    run_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 0, 16'h6543, 4'b0101);
    // Frames 8-10: constant inputs across wraps
    bus.blank_en = 1'b0;
    for (int f = 0; f < 3; f++)
      run_frame(8'h30, 8'h99, 8'h12, 8'h82, -1, 16'h0000, 4'b0000);
    mon_on = 1'b0;

    // Mid-frame reset takes effect without waiting for a clock
    repeat (6) @(negedge clk);
    clr = 1'b1;
    #1;
    check_reset("reset_async");
    @(posedge clk);
    #1;
    check_reset("reset_held");
    @(negedge clk);
    clr = 1'b0;
    // First frame after release shows cleared snapshot, then live inputs
    run_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, -1, 16'h0000, 4'b0000);
    run_frame(8'h30, 8'h99, 8'h12, 8'h82, -1, 16'h0000, 4'b0000);
    mon_on = 1'b0;

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d leftover entries expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
